// File: rtl/cgra_cfg_sequencer.sv
// CGRA configuration sequencer: queues CSR config writes in a small FIFO and replays each
// as a fixed-length write strobe; turns a level read request into a timed, sampled read.
module cgra_cfg_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_HOLD    = 4,
  parameter int RD_WAIT    = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic [ADDR_W-1:0]             cfg_addr_i,
  input  logic [DATA_W-1:0]             cfg_wdata_i,
  input  logic                          cfg_write_i,
  input  logic                          cfg_read_i,
  input  logic [DATA_W-1:0]             cgra_read_data_i,
  output logic [ADDR_W-1:0]             cgra_cfg_addr_o,
  output logic [DATA_W-1:0]             cgra_cfg_data_o,
  output logic                          cgra_cfg_write_o,
  output logic                          cgra_cfg_read_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rdata_valid_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int MAX_CNT = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int CMD_W   = ADDR_W + DATA_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD      = 2'd2;
  localparam logic [1:0] S_RD_HOLD = 2'd3;

  logic [CMD_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_write;
  logic              r_read;
  logic [DATA_W-1:0] r_rdata;
  logic              r_valid;
  logic              r_read_prev;
  logic              r_read_pend;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_rise;
  logic              w_start_rd;
  logic [CMD_W-1:0]  w_head;

  // Pops only happen from IDLE with data present, so an empty FIFO never pops and a
  // same-cycle push into an empty FIFO simply lands.
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
  assign w_push     = cfg_write_i && (!w_full || w_pop);
  assign w_rise     = cfg_read_i && !r_read_prev;
  assign w_start_rd = (r_state == S_IDLE) && (r_level == '0) && r_read_pend;
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {cfg_addr_i, cfg_wdata_i};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
      if (cfg_write_i && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_rdata     <= '0;
      r_valid     <= 1'b0;
      r_read_prev <= 1'b0;
      r_read_pend <= 1'b0;
    end else begin
      r_read_prev <= cfg_read_i;
      r_read_pend <= (r_read_pend & ~w_start_rd) | w_rise;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_addr  <= w_head[CMD_W-1:DATA_W];
            r_data  <= w_head[DATA_W-1:0];
            r_write <= 1'b1;
            r_cnt   <= CNT_W'(WR_HOLD - 1);
            r_state <= S_WR;
          end else if (w_start_rd) begin
            r_addr  <= cfg_addr_i;
            r_read  <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= CNT_W'(RD_WAIT - 1);
            r_state <= S_RD;
          end
        end
        S_WR: begin
          if (r_cnt == '0) begin
            r_write <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RD: begin
          if (r_cnt == '0) begin
            r_rdata <= cgra_read_data_i;
            r_valid <= 1'b1;
            r_state <= S_RD_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RD_HOLD: begin
          // Read enable follows the request level once the data has been sampled.
          if (!cfg_read_i) begin
            r_read  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cgra_cfg_addr_o  = r_addr;
  assign cgra_cfg_data_o  = r_data;
  assign cgra_cfg_write_o = r_write;
  assign cgra_cfg_read_o  = r_read;
  assign rdata_o          = r_rdata;
  assign rdata_valid_o    = r_valid;
  assign busy_o           = (r_state != S_IDLE) || (r_level != '0) || r_read_pend;
  assign overflow_o       = r_overflow;
  assign fifo_level_o     = r_level;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Bench for cgra_cfg_sequencer: directed scenarios then random traffic, all outputs
// compared each cycle against a timestamp-based transaction model.
module tb_cgra_cfg_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int WR_HOLD = 4;
  localparam int RD_WAIT = 4;
  localparam int W = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_write;
  logic              cfg_read;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_write;
  logic              w_read;
  logic [DATA_W-1:0] w_rdata;
  logic              w_valid;
  logic              w_busy;
  logic              w_ovf;
  logic [2:0]        w_level;
  logic [1:0]        w_state;

  cgra_cfg_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
    .WR_HOLD(WR_HOLD), .RD_WAIT(RD_WAIT)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .cfg_write_i(cfg_write),
    .cfg_read_i(cfg_read),
    .cgra_read_data_i(rd_data),
    .cgra_cfg_addr_o(w_addr),
    .cgra_cfg_data_o(w_data),
    .cgra_cfg_write_o(w_write),
    .cgra_cfg_read_o(w_read),
    .rdata_o(w_rdata),
    .rdata_valid_o(w_valid),
    .busy_o(w_busy),
    .overflow_o(w_ovf),
    .fifo_level_o(w_level),
    .dbg_state_o(w_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: waiting commands plus edge timestamps of the active operation
  logic [W-1:0]      m_q[$];
  logic [W-1:0]      exp_q[$];
  int                n = 0;
  int                write_end;
  int                next_free;
  int                sample_edge;
  bit                m_reading;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_rdata;
  logic              m_write, m_read, m_valid, m_ovf, m_pend, m_prev, m_busy;
  logic              prev_wr;
  int                wr_starts;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    write_end = -1; next_free = 0; sample_edge = -1; m_reading = 0;
    m_addr = '0; m_data = '0; m_rdata = '0;
    m_write = 0; m_read = 0; m_valid = 0; m_ovf = 0; m_pend = 0; m_prev = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] cmd;
    bit free, pop, start_rd, rise;
    n++;
    if (!rst_n) begin
      model_reset();
    end else begin
      rise     = cfg_read && !m_prev;
      free     = (n >= next_free) && !m_reading;
      pop      = free && (m_q.size() > 0);
      start_rd = free && (m_q.size() == 0) && m_pend;
      if (pop) begin
        cmd = m_q.pop_front();
        m_addr = cmd[W-1:DATA_W];
        m_data = cmd[DATA_W-1:0];
        m_write = 1;
        write_end = n + WR_HOLD;
        next_free = n + WR_HOLD + 1;
      end else if (n == write_end) begin
        m_write = 0;
      end
      if (cfg_write) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({cfg_addr, cfg_wdata});
          exp_q.push_back({cfg_addr, cfg_wdata});
        end else begin
          m_ovf = 1;
        end
      end
      if (start_rd) begin
        m_addr = cfg_addr; m_read = 1; m_valid = 0; m_pend = 0;
        sample_edge = n + RD_WAIT; m_reading = 1;
      end else if (m_reading) begin
        if (n == sample_edge) begin
          m_rdata = rd_data; m_valid = 1;
        end else if (n > sample_edge && !cfg_read) begin
          m_read = 0; m_reading = 0; next_free = n + 1;
        end
      end
      m_pend = m_pend | rise;
      m_prev = cfg_read;
    end
    m_busy = (n < write_end) || m_reading || (m_q.size() != 0) || m_pend;
  endtask

  // scoreboard + per-cycle comparison against the model
  task automatic check_all();
    logic [W-1:0] e;
    chk("write_o", W'(w_write), W'(m_write));
    chk("read_o", W'(w_read), W'(m_read));
    chk("cfg_addr", W'(w_addr), W'(m_addr));
    chk("cfg_data", W'(w_data), W'(m_data));
    chk("rdata", W'(w_rdata), W'(m_rdata));
    chk("rdata_valid", W'(w_valid), W'(m_valid));
    chk("busy", W'(w_busy), W'(m_busy));
    chk("overflow", W'(w_ovf), W'(m_ovf));
    chk("level", W'(w_level), W'(m_q.size()));
    chk("wr_rd_excl", W'(w_write & w_read), W'(0));
    if (w_write && !prev_wr) begin
      wr_starts++;
      chk("sb_pending", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_cmd", {w_addr, w_data}, e);
      end
    end
    prev_wr = w_write;
  endtask

  // driver: one clock with model update and output check
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (w_busy && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, W'(w_busy), W'(0));
  endtask

  initial begin
    int cnt, first_rd, last_wr, base;
    rst_n = 0; cfg_addr = '0; cfg_wdata = '0; cfg_write = 0; cfg_read = 0; rd_data = '0;
    prev_wr = 0; wr_starts = 0;
    model_reset();
    repeat (3) cycle();
    chk("rst_level", W'(w_level), W'(0));
    chk("rst_state", W'(w_state), W'(0));
    chk("rst_busy", W'(w_busy), W'(0));
    rst_n = 1;
    cycle();

    // async reset in the middle of a write
    cfg_addr = 32'h44; cfg_wdata = 32'h55; cfg_write = 1;
    cycle();
    cfg_write = 0;
    repeat (2) cycle();
    chk("pre_rst_write", W'(w_write), W'(1));
    rst_n = 0;
    #1;
    chk("arst_write", W'(w_write), W'(0));
    chk("arst_addr", W'(w_addr), W'(0));
    chk("arst_data", W'(w_data), W'(0));
    chk("arst_level", W'(w_level), W'(0));
    chk("arst_state", W'(w_state), W'(0));
    chk("arst_busy", W'(w_busy), W'(0));
    model_reset();
    repeat (2) cycle();
    rst_n = 1;
    cycle();

    // single write
    cfg_addr = 32'h10; cfg_wdata = 32'hDEAD; cfg_write = 1;
    cycle();
    cfg_write = 0;
    chk("single_level1", W'(w_level), W'(1));
    cycle();
    chk("single_level0", W'(w_level), W'(0));
    chk("single_wr_start", W'(w_write), W'(1));
    cnt = 1;
    repeat (10) begin
      cycle();
      if (w_write) begin
        cnt++;
        chk("single_addr", W'(w_addr), W'(32'h10));
        chk("single_data", W'(w_data), W'(32'hDEAD));
      end
    end
    chk("single_wr_len", W'(cnt), W'(WR_HOLD));

    // back-to-back pushes, overflow
    base = wr_starts;
    for (int i = 0; i < 8; i++) begin
      cfg_addr = 32'h100 + i; cfg_wdata = $urandom; cfg_write = 1;
      cycle();
    end
    cfg_write = 0;
    wait_idle("b2b_drain", 200);
    chk("b2b_overflow", W'(w_ovf), W'(1));
    chk("b2b_writes", W'(wr_starts - base), W'(6));

    // read
    cfg_addr = 32'h20; rd_data = 32'h1234; cfg_read = 1;
    cycle();
    cnt = 0;
    for (int k = 0; k < 20 && !w_valid; k++) begin
      cycle();
      if (w_read && !w_valid) cnt++;
    end
    chk("rd_wait_len", W'(cnt), W'(RD_WAIT));
    chk("rd_data", W'(w_rdata), W'(32'h1234));
    chk("rd_valid", W'(w_valid), W'(1));
    chk("rd_addr", W'(w_addr), W'(32'h20));
    repeat (2) cycle();
    chk("rd_hold", W'(w_read), W'(1));
    cfg_read = 0;
    cycle();
    chk("rd_release", W'(w_read), W'(0));
    wait_idle("rd_idle", 20);

    // write then read edge next cycle
    cfg_addr = 32'h30; cfg_wdata = 32'hBEEF; cfg_write = 1;
    cycle();
    cfg_write = 0; cfg_read = 1;
    first_rd = -1; last_wr = -1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (w_write) last_wr = k;
      if (w_read && first_rd < 0) first_rd = k;
    end
    chk("wr_then_rd", W'(first_rd > last_wr && last_wr >= 0), W'(1));
    cfg_read = 0;
    cycle();
    wait_idle("wr_rd_idle", 20);

    // held read: no second read; re-raise starts a new one
    rd_data = 32'hA5A5; cfg_read = 1;
    repeat (7) cycle();
    chk("held_valid", W'(w_valid), W'(1));
    chk("held_rdata", W'(w_rdata), W'(32'hA5A5));
    rd_data = 32'h5678;
    repeat (10) begin
      cycle();
      chk("held_no_reread", W'(w_rdata), W'(32'hA5A5));
    end
    cfg_read = 0;
    cycle();
    cfg_read = 1;
    cycle();
    cycle();
    chk("reraise_valid_drop", W'(w_valid), W'(0));
    repeat (RD_WAIT) cycle();
    chk("reraise_valid", W'(w_valid), W'(1));
    chk("reraise_rdata", W'(w_rdata), W'(32'h5678));
    cfg_read = 0;
    cycle();
    wait_idle("held_idle", 20);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cfg_write = ($urandom_range(0, 3) == 0);
      cfg_addr  = $urandom;
      cfg_wdata = $urandom;
      rd_data   = $urandom;
      if ($urandom_range(0, 11) == 0) cfg_read = ~cfg_read;
      cycle();
    end
    cfg_write = 0; cfg_read = 0;
    cycle();
    wait_idle("rand_drain", 300);
    chk("rand_sb_empty", W'(exp_q.size()), W'(0));
    chk("rand_level", W'(w_level), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
